// File: rtl/sim_run_pkg.sv
// sim_run_pkg: shared types for the bench run controller.
// State and verdict encodings plus counter sizing helpers.
package sim_run_pkg;

  typedef enum logic [1:0] {
    HOLD,
    RUN,
    DRAIN,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    FAIL_NONE,
    FAIL_ERROR,
    FAIL_TIMEOUT,
    FAIL_DEADLOCK
  } fail_code_t;

  localparam int FAIL_CH_W = 3;

  // Width able to hold 0..max; never narrower than one bit.
  function automatic int cnt_w(input int max);
    return (max < 1) ? 1 : $clog2(max + 1);
  endfunction

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sim_prio_enc.sv
// sim_prio_enc: lowest-index-wins priority encoder.
// Reports the index of the lowest set request bit plus a valid flag.
module sim_prio_enc #(
  parameter int N = 1,
  parameter int W = 1
) (
  input  logic [N-1:0] req,
  output logic [W-1:0] idx,
  output logic         valid
);

  always_comb begin
    idx   = '0;
    valid = |req;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) idx = W'(i);
    end
  end

endmodule

// File: rtl/sim_run_ctrl.sv
// sim_run_ctrl: DUT reset sequencing and sticky run verdict.
// Watches halt/error/commit on N channels for pass, timeout, deadlock.
module sim_run_ctrl
  import sim_run_pkg::*;
#(
  parameter int     NUM_CH       = 1,
  parameter int     RST_CYCLES   = 2,
  parameter longint TIMEOUT      = 10000000,
  parameter int     WDOG_CYCLES  = 100000,
  parameter int     DRAIN_CYCLES = 2,
  parameter bit     HALT_ALL     = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_CH-1:0]    halt,
  input  logic [NUM_CH-1:0]    error,
  input  logic [NUM_CH-1:0]    commit,
  output logic                 dut_rst,
  output logic                 running,
  output logic                 done,
  output logic                 pass,
  output logic [1:0]           fail_code,
  output logic [FAIL_CH_W-1:0] fail_ch,
  output logic [63:0]          cycle_count
);

  localparam int HW = cnt_w(RST_CYCLES);
  localparam int WW = cnt_w(WDOG_CYCLES);
  localparam int DW = cnt_w(DRAIN_CYCLES);
  localparam int IW = idx_w(NUM_CH);

  state_t               state;
  state_t               state_nxt;
  logic [HW-1:0]        hold_cnt;
  logic [WW-1:0]        wdog_cnt;
  logic [DW-1:0]        drain_cnt;
  logic [NUM_CH-1:0]    halted;
  fail_code_t           code_q;
  logic                 pass_q;
  logic [FAIL_CH_W-1:0] ch_q;
  logic [63:0]          cnt_q;

  logic [IW-1:0]        err_idx;
  logic                 err_vld;
  logic                 any_commit;
  logic                 hold_last;
  logic                 drain_last;
  logic                 ev_tmo;
  logic                 ev_wdog;
  logic                 ev_halt;

  sim_prio_enc #(
    .N (NUM_CH),
    .W (IW)
  ) u_enc (
    .req   (error),
    .idx   (err_idx),
    .valid (err_vld)
  );

  assign any_commit = |commit;
  assign hold_last  = (hold_cnt == HW'(RST_CYCLES - 1));
  assign drain_last = (DRAIN_CYCLES == 0) ||
                      (drain_cnt == DW'(DRAIN_CYCLES - 1));

  assign ev_tmo  = (TIMEOUT != 0) &&
                   (cnt_q == 64'(TIMEOUT - 1));
  assign ev_wdog = (WDOG_CYCLES != 0) && !any_commit &&
                   (wdog_cnt == WW'(WDOG_CYCLES - 1));
  assign ev_halt = HALT_ALL ? (&(halted | halt)) : (|halt);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= HOLD;
    else     state <= state_nxt;
  end

  // Next state; error outranks timeout, deadlock and halt
  always_comb begin
    state_nxt = state;
    unique case (state)
      HOLD: begin
        if (hold_last) state_nxt = RUN;
      end
      RUN: begin
        if (err_vld) begin
          state_nxt = (DRAIN_CYCLES == 0) ? DONE : DRAIN;
        end else if (ev_tmo || ev_wdog || ev_halt) begin
          state_nxt = DONE;
        end
      end
      DRAIN: begin
        if (drain_last) state_nxt = DONE;
      end
      DONE: begin
        state_nxt = DONE;
      end
    endcase
  end

  // Outputs
  always_comb begin
    dut_rst     = (state == HOLD);
    running     = (state == RUN);
    done        = (state == DONE);
    pass        = pass_q;
    fail_code   = code_q;
    fail_ch     = ch_q;
    cycle_count = cnt_q;
  end

  // Counters and sticky verdict; nothing moves once DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt  <= '0;
      wdog_cnt  <= '0;
      drain_cnt <= '0;
      halted    <= '0;
      code_q    <= FAIL_NONE;
      pass_q    <= 1'b0;
      ch_q      <= '0;
      cnt_q     <= '0;
    end else begin
      unique case (state)
        HOLD: begin
          if (!hold_last) hold_cnt <= hold_cnt + 1'b1;
        end
        RUN: begin
          if (~&cnt_q) cnt_q <= cnt_q + 64'd1;
          halted <= halted | halt;
          if (any_commit) wdog_cnt <= '0;
          else            wdog_cnt <= wdog_cnt + 1'b1;
          if (err_vld) begin
            code_q <= FAIL_ERROR;
            ch_q   <= FAIL_CH_W'(err_idx);
          end else if (ev_tmo) begin
            code_q <= FAIL_TIMEOUT;
          end else if (ev_wdog) begin
            code_q <= FAIL_DEADLOCK;
          end else if (ev_halt) begin
            pass_q <= 1'b1;
          end
        end
        DRAIN: begin
          if (~&cnt_q) cnt_q <= cnt_q + 64'd1;
          drain_cnt <= drain_cnt + 1'b1;
        end
        DONE: begin
          cnt_q <= cnt_q;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sim_run_ctrl.sv
// tb_sim_run_ctrl: directed checks of the run controller.
// Two instances: a 2-channel halt-all bench and a 4-channel first-halt bench.
module tb_sim_run_ctrl;
  import sim_run_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic [1:0]  halt = '0;
  logic [1:0]  error = '0;
  logic [1:0]  commit = '0;
  logic        dut_rst, running, done, pass;
  logic [1:0]  fail_code;
  logic [2:0]  fail_ch;
  logic [63:0] cycle_count;

  logic        rst_b = 1'b1;
  logic [3:0]  halt_b = '0;
  logic [3:0]  error_b = '0;
  logic [3:0]  commit_b = '0;
  logic        dut_rst_b, running_b, done_b, pass_b;
  logic [1:0]  fail_code_b;
  logic [2:0]  fail_ch_b;
  logic [63:0] cycle_count_b;

  int checks = 0;
  int errors = 0;

  sim_run_ctrl #(
    .NUM_CH(2), .RST_CYCLES(2), .TIMEOUT(50),
    .WDOG_CYCLES(8), .DRAIN_CYCLES(2), .HALT_ALL(1'b1)
  ) u_a (
    .clk(clk), .rst(rst), .halt(halt), .error(error),
    .commit(commit), .dut_rst(dut_rst), .running(running),
    .done(done), .pass(pass), .fail_code(fail_code),
    .fail_ch(fail_ch), .cycle_count(cycle_count)
  );

  sim_run_ctrl #(
    .NUM_CH(4), .RST_CYCLES(1), .TIMEOUT(0),
    .WDOG_CYCLES(0), .DRAIN_CYCLES(0), .HALT_ALL(1'b0)
  ) u_b (
    .clk(clk), .rst(rst_b), .halt(halt_b), .error(error_b),
    .commit(commit_b), .dut_rst(dut_rst_b), .running(running_b),
    .done(done_b), .pass(pass_b), .fail_code(fail_code_b),
    .fail_ch(fail_ch_b), .cycle_count(cycle_count_b)
  );

  typedef struct {
    logic [1:0]  halt;
    logic [1:0]  error;
    logic [1:0]  commit;
    logic        run;
    logic        dn;
    logic        ps;
    logic [1:0]  code;
    logic [2:0]  ch;
    logic [63:0] cc;
  } vec_t;

  vec_t vt[$];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic chk_a(input string tag, input logic r,
                       input logic d, input logic p,
                       input logic [1:0] code, input logic [2:0] ch,
                       input logic [63:0] cc);
    chk({tag, ".running"}, 64'(running), 64'(r));
    chk({tag, ".done"}, 64'(done), 64'(d));
    chk({tag, ".pass"}, 64'(pass), 64'(p));
    chk({tag, ".fail_code"}, 64'(fail_code), 64'(code));
    chk({tag, ".fail_ch"}, 64'(fail_ch), 64'(ch));
    chk({tag, ".cycle_count"}, cycle_count, cc);
  endtask

  task automatic chk_reset_a(input string tag);
    chk({tag, ".dut_rst"}, 64'(dut_rst), 64'd1);
    chk_a(tag, 1'b0, 1'b0, 1'b0, 2'd0, 3'd0, 64'd0);
  endtask

  // Leaves instance A in its first RUN cycle (cycle_count 0)
  task automatic start_a;
    rst = 1'b1;
    halt = '0;
    error = '0;
    commit = '0;
    repeat (3) tick;
    rst = 1'b0;
    tick;
    tick;
  endtask

  task automatic start_b;
    rst_b = 1'b1;
    halt_b = '0;
    error_b = '0;
    commit_b = '0;
    tick;
    rst_b = 1'b0;
    tick;
  endtask

  function automatic vec_t mkv(input logic [1:0] h, input logic [1:0] e,
                               input logic [1:0] c, input logic r,
                               input logic d, input logic p,
                               input logic [1:0] code, input logic [2:0] ch,
                               input logic [63:0] cc);
    vec_t v;
    v.halt = h; v.error = e; v.commit = c;
    v.run = r; v.dn = d; v.ps = p;
    v.code = code; v.ch = ch; v.cc = cc;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1, "bench hung");
  end

  initial begin
    // Reset release timing
    repeat (3) tick;
    chk_reset_a("rst_hold");
    rst = 1'b0;
    chk("rel0.dut_rst", 64'(dut_rst), 64'd1);
    tick;
    chk("rel1.dut_rst", 64'(dut_rst), 64'd1);
    chk("rel1.running", 64'(running), 64'd0);
    tick;
    chk("rel2.dut_rst", 64'(dut_rst), 64'd0);
    chk("rel2.running", 64'(running), 64'd1);
    chk("rel2.cycle_count", cycle_count, 64'd0);

    // Halt-all pass: channel 0 at 10, channel 1 at 25
    commit = 2'b11;
    for (int c = 0; c <= 25; c++) begin
      halt = (c == 10) ? 2'b01 : (c == 25) ? 2'b10 : 2'b00;
      tick;
      if (c == 24) chk_a("halt_c24", 1'b1, 1'b0, 1'b0, 2'd0, 3'd0, 64'd25);
    end
    halt = '0;
    chk_a("halt_done", 1'b0, 1'b1, 1'b1, 2'd0, 3'd0, 64'd26);
    chk("halt_done.dut_rst", 64'(dut_rst), 64'd0);
    error = 2'b11;
    halt = 2'b11;
    commit = 2'b00;
    repeat (3) tick;
    chk_a("frozen", 1'b0, 1'b1, 1'b1, 2'd0, 3'd0, 64'd26);

    // Error with coincident halt, then drain (table-driven)
    for (int i = 0; i < 5; i++)
      vt.push_back(mkv(2'b00, 2'b00, 2'b11, 1'b1, 1'b0, 1'b0,
                       2'd0, 3'd0, 64'(i + 1)));
    vt.push_back(mkv(2'b10, 2'b10, 2'b11, 1'b0, 1'b0, 1'b0, 2'd1, 3'd1, 64'd6));
    vt.push_back(mkv(2'b00, 2'b01, 2'b11, 1'b0, 1'b0, 1'b0, 2'd1, 3'd1, 64'd7));
    vt.push_back(mkv(2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 2'd1, 3'd1, 64'd8));
    vt.push_back(mkv(2'b11, 2'b11, 2'b11, 1'b0, 1'b1, 1'b0, 2'd1, 3'd1, 64'd8));
    start_a;
    foreach (vt[i]) begin
      halt = vt[i].halt;
      error = vt[i].error;
      commit = vt[i].commit;
      tick;
      chk_a($sformatf("drain_row%0d", i), vt[i].run, vt[i].dn, vt[i].ps,
            vt[i].code, vt[i].ch, vt[i].cc);
    end

    // Timeout with steady commits
    start_a;
    commit = 2'b11;
    for (int c = 0; c <= 49; c++) begin
      tick;
      if (c == 48) chk_a("tmo_c48", 1'b1, 1'b0, 1'b0, 2'd0, 3'd0, 64'd49);
    end
    chk_a("tmo_done", 1'b0, 1'b1, 1'b0, 2'd2, 3'd0, 64'd50);

    // Halt on the timeout cycle still reports timeout
    start_a;
    commit = 2'b11;
    for (int c = 0; c <= 49; c++) begin
      halt = (c == 49) ? 2'b11 : 2'b00;
      tick;
    end
    halt = '0;
    chk_a("tmo_halt", 1'b0, 1'b1, 1'b0, 2'd2, 3'd0, 64'd50);

    // Deadlock: commits stop after cycle 5
    start_a;
    for (int c = 0; c <= 13; c++) begin
      commit = (c <= 5) ? 2'b11 : 2'b00;
      tick;
      if (c == 12) chk_a("wdog_c12", 1'b1, 1'b0, 1'b0, 2'd0, 3'd0, 64'd13);
    end
    commit = '0;
    chk_a("wdog_done", 1'b0, 1'b1, 1'b0, 2'd3, 3'd0, 64'd14);

    // Commits every 7 cycles keep the watchdog quiet until timeout
    start_a;
    for (int c = 0; c <= 49; c++) begin
      commit = (c % 7 == 0) ? 2'b01 : 2'b00;
      tick;
      if (c == 48) chk_a("wdog7_c48", 1'b1, 1'b0, 1'b0, 2'd0, 3'd0, 64'd49);
    end
    commit = '0;
    chk_a("wdog7_done", 1'b0, 1'b1, 1'b0, 2'd2, 3'd0, 64'd50);

    // Reset mid-run clears the halted mask
    start_a;
    commit = 2'b11;
    for (int c = 0; c <= 9; c++) begin
      halt = (c == 2) ? 2'b01 : 2'b00;
      tick;
    end
    halt = '0;
    rst = 1'b1;
    tick;
    chk_reset_a("rst_run");
    rst = 1'b0;
    tick;
    tick;
    chk("fresh.running", 64'(running), 64'd1);
    for (int c = 0; c <= 4; c++) begin
      halt = (c == 4) ? 2'b10 : 2'b00;
      tick;
    end
    chk_a("fresh_half", 1'b1, 1'b0, 1'b0, 2'd0, 3'd0, 64'd5);
    halt = 2'b01;
    tick;
    halt = '0;
    chk_a("fresh_pass", 1'b0, 1'b1, 1'b1, 2'd0, 3'd0, 64'd6);

    // Reset from DONE, then both channels error together
    rst = 1'b1;
    tick;
    chk_reset_a("rst_done");
    rst = 1'b0;
    tick;
    tick;
    error = 2'b11;
    tick;
    error = '0;
    chk_a("err_both", 1'b0, 1'b0, 1'b0, 2'd1, 3'd0, 64'd1);
    tick;
    tick;
    chk_a("err_both_done", 1'b0, 1'b1, 1'b0, 2'd1, 3'd0, 64'd3);

    // Instance B: single reset cycle, no drain, watchdog off
    start_b;
    chk("b_start.dut_rst", 64'(dut_rst_b), 64'd0);
    chk("b_start.running", 64'(running_b), 64'd1);
    repeat (20) tick;
    chk("b_idle.running", 64'(running_b), 64'd1);
    chk("b_idle.cycle_count", cycle_count_b, 64'd20);
    error_b = 4'b1100;
    tick;
    error_b = '0;
    chk("b_err.done", 64'(done_b), 64'd1);
    chk("b_err.fail_code", 64'(fail_code_b), 64'd1);
    chk("b_err.fail_ch", 64'(fail_ch_b), 64'd2);
    chk("b_err.cycle_count", cycle_count_b, 64'd21);

    start_b;
    tick;
    halt_b = 4'b0100;
    tick;
    halt_b = '0;
    chk("b_halt.done", 64'(done_b), 64'd1);
    chk("b_halt.pass", 64'(pass_b), 64'd1);
    chk("b_halt.fail_code", 64'(fail_code_b), 64'd0);
    chk("b_halt.cycle_count", cycle_count_b, 64'd2);

    start_b;
    halt_b = 4'b0001;
    error_b = 4'b1000;
    tick;
    halt_b = '0;
    error_b = '0;
    chk("b_mix.done", 64'(done_b), 64'd1);
    chk("b_mix.pass", 64'(pass_b), 64'd0);
    chk("b_mix.fail_code", 64'(fail_code_b), 64'd1);
    chk("b_mix.fail_ch", 64'(fail_ch_b), 64'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
